sector_write: RTL and testbench
===============================

Name: sector_write

Overview:
- Write-direction counterpart of the sector read channel in the disk emulator.
- Takes the controller's serial write stream, one bit per clk, in the same bit-cell timing the read channel uses, while write gate is active in the sector data area.
- Finds the sync bit after the data preamble, deserialises data bytes MSB first, and issues byte writes into the sector buffer RAM at consecutive addresses 0..DATA_BYTES-1.
- Reports sector completion, overrun, and sync failure to the host-side logic.

Parameters:
- DATA_BYTES, 408: data bytes per sector.
- ADDR_W, 9: sector buffer address width; must satisfy 2**ADDR_W >= DATA_BYTES.
- SYNC_TIMEOUT, 255: maximum preamble bit cells allowed before sync. Used only with SECTOR_WRITE_SYNC_TIMEOUT_EN.

Ports:
- clk  in  1  bit-cell clock, shared with the read channel
- rst_n  in  1  synchronous active-low reset
- sector_strobe  in  1  one-cycle pulse at each sector boundary
- data_area  in  1  high while the read channel is in its data gap or data field
- wr_gate  in  1  controller write gate
- wr_bit  in  1  serial write data, sampled every clk
- byte_out  out  8  assembled data byte
- addr_out  out  ADDR_W  sector buffer address for byte_out
- byte_we  out  1  one-cycle write enable for byte_out/addr_out
- sector_done  out  1  one-cycle pulse after byte DATA_BYTES-1 is written
- overrun  out  1  sticky: a 1 bit was received after the sector was complete
- sync_err  out  1  sticky: sync timeout (optional feature)

Behaviour:
- Reset: one clock with rst_n=0 forces state to IDLE and clears all counters and the shift register. Every output goes to 0: byte_out=0, addr_out=0, byte_we=0, sector_done=0, overrun=0, sync_err=0. Reset has priority over sector_strobe.
- States: IDLE, HUNT, SHIFT, DONE.
- IDLE: when wr_gate=1 and data_area=1, go to HUNT. Otherwise stay.
- HUNT:
  - wr_bit=0 is preamble; stay.
  - The first wr_bit=1 is the sync bit and is not stored. Go to SHIFT with bit_cnt=0 and byte_cnt=0.
  - If wr_gate=0, go to IDLE.
- SHIFT:
  - Each cycle: shreg <= {shreg[6:0], wr_bit}; bit_cnt increments, 3 bits, wrapping.
  - On the cycle where bit_cnt==7, on the next edge: byte_out <= {shreg[6:0], wr_bit}, addr_out <= byte_cnt, byte_we=1 for exactly one cycle, and byte_cnt increments.
  - Latency: byte_we is asserted 1 clk after the 8th bit of a byte is sampled. byte_out and addr_out hold until the next write.
  - When byte DATA_BYTES-1 is written, sector_done pulses in the same cycle as its byte_we, and the state goes to DONE.
  - wr_gate=0 mid-sector: go to IDLE. The partial byte is discarded, bytes already written stand, and sector_done does not pulse.
- DONE: stay until sector_strobe or wr_gate=0, then go to IDLE. Any wr_bit=1 while wr_gate=1 sets overrun. No further byte_we is issued.
- sector_strobe, from any state:
  - Next state is IDLE and any in-progress byte is aborted.
  - Clears overrun and sync_err.
  - Highest priority after reset, including over a simultaneous byte completion: that byte is not written.
  - Evaluation from IDLE resumes the following cycle.
- byte_cnt never exceeds DATA_BYTES-1. addr_out never wraps within a sector.
- data_area is checked only on the IDLE->HUNT transition. Dropping it later does not abort.

Optional Feature:
- Macro: SECTOR_WRITE_SYNC_TIMEOUT_EN.
- Enabled:
  - HUNT counts preamble cells.
  - If SYNC_TIMEOUT cells pass with no sync, sync_err sets and the state goes to DONE.
  - No bytes are written and sector_done does not pulse.
  - The counter clears on entry to HUNT.
- Disabled: HUNT waits indefinitely and sync_err is tied to 0.

Decomposition:
- Package disk_fmt_pkg holds:
  - state enum for this block
  - DATA_BYTES=408
  - ADDR_GAP_MAX=207, ADDR_MAX=31, DATA_GAP_MAX=207
  - ADDR_W=9
  - The read channel imports the same constants.
- Sub-module bit_deserializer: 8-bit MSB-first shifter plus 3-bit counter. Inputs: clk, rst_n, clear, shift_en, bit_in. Outputs: byte_valid and a byte output. The FSM and address counter stay in sector_write.

Test Plan:
- Full sector: wr_gate and data_area high, 20 zeros, a 1, then bytes 0x00..0xFF,0x00..0x97 (408 bytes) -> 408 byte_we pulses, addr 0..407, byte_out equal to the sent data, 1 clk after each 8th bit; sector_done coincident with addr 407.
- Gate drop: wr_gate falls after 3 bytes plus 5 bits -> exactly 3 writes (addr 0..2), no sector_done, state IDLE.
- Overrun: after a full sector, keep wr_gate=1 and send bit 1 -> overrun=1 and stays 1; the next sector_strobe clears it.
- Strobe collision: sector_strobe on the same cycle as the 8th bit of byte 10 -> no byte_we for that byte; next sector restarts at addr 0.
- Reset mid-SHIFT: rst_n=0 for 1 clk -> all outputs 0; no write occurs until a fresh sync.
- With SECTOR_WRITE_SYNC_TIMEOUT_EN and SYNC_TIMEOUT=255: 300 zeros -> sync_err=1 after 255 cells; zero byte_we.

Source files
------------

// File: rtl/disk_fmt_pkg.sv
// Disk format constants and the sector_write state encoding.
// The read channel imports the same field sizes.
package disk_fmt_pkg;

   localparam int DATA_BYTES   = 408;
   localparam int ADDR_GAP_MAX = 207;
   localparam int ADDR_MAX     = 31;
   localparam int DATA_GAP_MAX = 207;
   localparam int ADDR_W       = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HUNT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } sw_state_t;

endpackage

// File: rtl/bit_deserializer.sv
// MSB-first serial-to-byte shifter with a 3-bit cell counter.
// o_byte_valid is combinational: high on the cell that supplies the 8th bit.
module bit_deserializer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clear,
   input  logic       i_shift_en,
   input  logic       i_bit_in,
   output logic       o_byte_valid,
   output logic [7:0] o_byte
);

   logic [6:0] r_shreg;
   logic [2:0] r_bit_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (i_shift_en) begin
         r_shreg   <= {r_shreg[5:0], i_bit_in};
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   // Only seven history bits are kept; the eighth comes straight from the line.
   assign o_byte_valid = i_shift_en && (r_bit_cnt == 3'd7);
   assign o_byte       = {r_shreg, i_bit_in};

endmodule

// File: rtl/sector_write.sv
// Write channel: finds the sync bit, deserialises bytes and writes them to the sector buffer.
// Optional sync timeout in HUNT is enabled by SECTOR_WRITE_SYNC_TIMEOUT_EN.
module sector_write
   import disk_fmt_pkg::*;
#(
   parameter int DATA_BYTES = disk_fmt_pkg::DATA_BYTES,
   parameter int ADDR_W     = disk_fmt_pkg::ADDR_W
`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
   ,
   parameter int SYNC_TIMEOUT = 255
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_sector_strobe,
   input  logic              i_data_area,
   input  logic              i_wr_gate,
   input  logic              i_wr_bit,
   output logic [7:0]        o_byte_out,
   output logic [ADDR_W-1:0] o_addr_out,
   output logic              o_byte_we,
   output logic              o_sector_done,
   output logic              o_overrun,
   output logic              o_sync_err
);

   sw_state_t         r_state;
   logic [ADDR_W-1:0] r_byte_cnt;
   logic [7:0]        r_byte_out;
   logic [ADDR_W-1:0] r_addr_out;
   logic              r_byte_we;
   logic              r_sector_done;
   logic              r_overrun;
   logic              r_sync_err;

   logic              w_shift_en;
   logic              w_clear;
   logic              w_byte_valid;
   logic [7:0]        w_byte;

   // A strobe or gate drop on the 8th cell suppresses that byte entirely.
   assign w_shift_en = (r_state == ST_SHIFT) && i_wr_gate && !i_sector_strobe;
   assign w_clear    = (r_state != ST_SHIFT) || i_sector_strobe;

   bit_deserializer u_deser (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (w_clear),
      .i_shift_en   (w_shift_en),
      .i_bit_in     (i_wr_bit),
      .o_byte_valid (w_byte_valid),
      .o_byte       (w_byte)
   );

`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
   localparam int HUNT_W = $clog2(SYNC_TIMEOUT + 1);
   logic [HUNT_W-1:0] r_hunt_cnt;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_byte_cnt    <= '0;
         r_byte_out    <= '0;
         r_addr_out    <= '0;
         r_byte_we     <= 1'b0;
         r_sector_done <= 1'b0;
         r_overrun     <= 1'b0;
         r_sync_err    <= 1'b0;
`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
         r_hunt_cnt    <= '0;
`endif
      end else begin
         r_byte_we     <= 1'b0;
         r_sector_done <= 1'b0;
         if (i_sector_strobe) begin
            r_state    <= ST_IDLE;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_wr_gate && i_data_area) begin
                     r_state <= ST_HUNT;
`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
                     r_hunt_cnt <= '0;
`endif
                  end
               end
               ST_HUNT: begin
                  if (!i_wr_gate) begin
                     r_state <= ST_IDLE;
                  end else if (i_wr_bit) begin
                     r_state    <= ST_SHIFT;
                     r_byte_cnt <= '0;
                  end
`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
                  else if (r_hunt_cnt == HUNT_W'(SYNC_TIMEOUT - 1)) begin
                     r_sync_err <= 1'b1;
                     r_state    <= ST_DONE;
                  end else begin
                     r_hunt_cnt <= r_hunt_cnt + 1'b1;
                  end
`endif
               end
               ST_SHIFT: begin
                  if (!i_wr_gate) begin
                     r_state <= ST_IDLE;
                  end else if (w_byte_valid) begin
                     r_byte_out <= w_byte;
                     r_addr_out <= r_byte_cnt;
                     r_byte_we  <= 1'b1;
                     if (r_byte_cnt == ADDR_W'(DATA_BYTES - 1)) begin
                        r_sector_done <= 1'b1;
                        r_state       <= ST_DONE;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                     end
                  end
               end
               ST_DONE: begin
                  if (i_wr_gate && i_wr_bit) r_overrun <= 1'b1;
                  if (!i_wr_gate) r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_byte_out    = r_byte_out;
   assign o_addr_out    = r_addr_out;
   assign o_byte_we     = r_byte_we;
   assign o_sector_done = r_sector_done;
   assign o_overrun     = r_overrun;
   assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_sector_write.sv
// Directed bench for sector_write: full sector, gate drop, overrun, strobe collision, reset, sync hunt.
module tb_sector_write;
   import disk_fmt_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sector_strobe = 1'b0;
   logic       data_area = 1'b0;
   logic       wr_gate = 1'b0;
   logic       wr_bit = 1'b0;
   logic [7:0] byte_out;
   logic [8:0] addr_out;
   logic       byte_we;
   logic       sector_done;
   logic       overrun;
   logic       sync_err;

   int n_chk = 0;
   int n_fail = 0;
   int we_total = 0;
   int done_total = 0;

   always #5 clk = ~clk;

   sector_write dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_sector_strobe (sector_strobe),
      .i_data_area     (data_area),
      .i_wr_gate       (wr_gate),
      .i_wr_bit        (wr_bit),
      .o_byte_out      (byte_out),
      .o_addr_out      (addr_out),
      .o_byte_we       (byte_we),
      .o_sector_done   (sector_done),
      .o_overrun       (overrun),
      .o_sync_err      (sync_err)
   );

   always @(negedge clk) begin
      if (byte_we) we_total++;
      if (sector_done) done_total++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      wr_bit = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic chk_write(input string tag, input logic [7:0] d, input logic [8:0] a);
      chk({tag, "_we"}, 32'(byte_we), 32'd1);
      chk({tag, "_addr"}, 32'(addr_out), 32'(a));
      chk({tag, "_data"}, 32'(byte_out), 32'(d));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte"}, 32'(byte_out), 32'd0);
      chk({tag, "_addr"}, 32'(addr_out), 32'd0);
      chk({tag, "_we"}, 32'(byte_we), 32'd0);
      chk({tag, "_done"}, 32'(sector_done), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun), 32'd0);
      chk({tag, "_serr"}, 32'(sync_err), 32'd0);
   endtask

   initial begin
      int we0, done0, bad;
      logic [7:0] k8;

      // Reset
      @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
      rst_n = 1'b1;

      // data_area low keeps IDLE
      wr_gate = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("no_data_area_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk("no_data_area_we", 32'(we_total), 32'd0);

      // Full sector: 20 zeros (first consumed in IDLE), sync, 408 bytes
      data_area = 1'b1;
      we0 = we_total;
      done0 = done_total;
      send_zeros(20);
      send_bit(1'b1);
      bad = 0;
      for (int k = 0; k < 408; k++) begin
         k8 = k[7:0];
         send_byte(k8);
         if (byte_we !== 1'b1 || addr_out !== 9'(k) || byte_out !== k8) bad++;
         if (k < 407 && sector_done !== 1'b0) bad++;
      end
      chk("full_bad_bytes", 32'(bad), 32'd0);
      chk("full_last_done", 32'(sector_done), 32'd1);
      chk_write("full_last", 8'h97, 9'd407);
      chk("full_we_count", 32'(we_total - we0), 32'd407);
      send_bit(1'b0);
      chk("full_we_count_after", 32'(we_total - we0), 32'd408);
      chk("full_done_count", 32'(done_total - done0), 32'd1);
      chk("full_done_pulse", 32'(sector_done), 32'd0);
      chk("full_state_done", 32'(dut.r_state), 32'(ST_DONE));

      // Overrun
      send_bit(1'b0);
      chk("ovr_before", 32'(overrun), 32'd0);
      send_bit(1'b1);
      chk("ovr_set", 32'(overrun), 32'd1);
      send_zeros(9);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      chk("ovr_no_we", 32'(we_total - we0), 32'd408);
      sector_strobe = 1'b1;
      send_bit(1'b0);
      sector_strobe = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'd0);
      chk("ovr_strobe_idle", 32'(dut.r_state), 32'(ST_IDLE));

      // Gate drop after 3 bytes + 5 bits
      we0 = we_total;
      done0 = done_total;
      send_zeros(6);
      send_bit(1'b1);
      send_byte(8'hA5);
      chk_write("gd_b0", 8'hA5, 9'd0);
      send_byte(8'h3C);
      chk_write("gd_b1", 8'h3C, 9'd1);
      send_byte(8'h7E);
      chk_write("gd_b2", 8'h7E, 9'd2);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      wr_gate = 1'b0;
      send_bit(1'b1);
      send_zeros(4);
      chk("gd_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk("gd_we_count", 32'(we_total - we0), 32'd3);
      chk("gd_no_done", 32'(done_total - done0), 32'd0);
      chk("gd_hold_addr", 32'(addr_out), 32'd2);
      chk("gd_hold_data", 32'(byte_out), 32'h7E);

      // Strobe collides with 8th bit of byte 10
      wr_gate = 1'b1;
      we0 = we_total;
      send_zeros(4);
      send_bit(1'b1);
      for (int k = 0; k < 10; k++) send_byte(8'hF0 + 8'(k));
      chk_write("sc_b9", 8'hF9, 9'd9);
      for (int i = 7; i >= 1; i--) send_bit(1'b1);
      sector_strobe = 1'b1;
      send_bit(1'b1);
      sector_strobe = 1'b0;
      chk("sc_no_we", 32'(byte_we), 32'd0);
      chk("sc_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk("sc_we_count", 32'(we_total - we0), 32'd10);
      chk("sc_hold_addr", 32'(addr_out), 32'd9);
      send_zeros(3);
      send_bit(1'b1);
      send_byte(8'h5A);
      chk_write("sc_restart", 8'h5A, 9'd0);

      // Reset mid-SHIFT, with gate still high
      sector_strobe = 1'b1;
      send_bit(1'b0);
      sector_strobe = 1'b0;
      send_zeros(2);
      send_bit(1'b1);
      send_byte(8'hC3);
      chk_write("rs_pre", 8'hC3, 9'd0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rst_n = 1'b0;
      send_bit(1'b1);
      rst_n = 1'b1;
      chk_all_zero("rs");
      we0 = we_total;
      send_zeros(12);
      chk("rs_no_we", 32'(we_total - we0), 32'd0);
      send_bit(1'b1);
      data_area = 1'b0;
      send_byte(8'h81);
      chk_write("rs_fresh", 8'h81, 9'd0);
      send_byte(8'h42);
      chk_write("rs_fresh2", 8'h42, 9'd1);

      // Long preamble
      data_area = 1'b1;
      sector_strobe = 1'b1;
      send_bit(1'b0);
      sector_strobe = 1'b0;
      we0 = we_total;
      send_bit(1'b0);
`ifdef SECTOR_WRITE_SYNC_TIMEOUT_EN
      send_zeros(254);
      chk("to_before", 32'(sync_err), 32'd0);
      send_bit(1'b0);
      chk("to_set", 32'(sync_err), 32'd1);
      send_zeros(45);
      chk("to_state", 32'(dut.r_state), 32'(ST_DONE));
      chk("to_no_we", 32'(we_total - we0), 32'd0);
      sector_strobe = 1'b1;
      send_bit(1'b0);
      sector_strobe = 1'b0;
      chk("to_cleared", 32'(sync_err), 32'd0);
`else
      send_zeros(300);
      chk("hunt_no_err", 32'(sync_err), 32'd0);
      chk("hunt_state", 32'(dut.r_state), 32'(ST_HUNT));
      chk("hunt_no_we", 32'(we_total - we0), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
